// File: rtl/rd_subtractor_pipe_if.sv
// Operand/result handshake bundle for the recursive-doubling subtractor.
// master: upstream producer and downstream consumer side; slave: the pipeline.
interface rd_subtractor_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Ovf
    );
endinterface

// File: rtl/rd_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: Diff = A - B - Bin computed as A + ~B + ~Bin.
// Stage 0 captures bitwise generate/propagate, stages 1..LEVELS run one prefix
// level each, the last stage forms Diff/Bout/Ovf. Elastic valid/ready chain,
// bubbles collapse, LEVELS+2 bundles of capacity.
//
// The prefix vectors are WIDTH+1 bits wide: index 0 carries the borrow-in term
// (~Bin) as a generate with propagate 0, index i+1 is operand bit i. After
// LEVELS levels, index i holds the carry into operand bit i. Index WIDTH only
// spans indices 1..WIDTH, so the carry-out takes one extra combine with index 0
// in the final stage.
module rd_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    rd_subtractor_pipe_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int NSTG   = LEVELS + 2;
    localparam int EW     = WIDTH + 1;

    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  en;
    logic [NSTG-1:0]  up_v;
    logic [NSTG-1:0]  ld;

    logic [EW-1:0]    g_q  [LEVELS+1];
    logic [EW-1:0]    g_d  [LEVELS+1];
    logic [EW-1:0]    gp_q [LEVELS+1];
    logic [EW-1:0]    gp_d [LEVELS+1];
    logic [WIDTH-1:0] pb_q [LEVELS+1];
    logic [WIDTH-1:0] pb_d [LEVELS+1];
    logic [LEVELS:0]  am_q, am_d;
    logic [LEVELS:0]  bm_q, bm_d;

    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             cout;

    // Stage enables: a stage may load when any stage at or after it is empty,
    // or the output is being taken this cycle.
    always_comb begin
        logic full;
        full = 1'b1;
        en   = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            full  = full & vld_q[k];
            en[k] = bus.out_ready | ~full;
        end
        up_v  = {vld_q[NSTG-2:0], bus.in_valid};
        ld    = en & up_v;
        vld_d = (en & up_v) | (~en & vld_q);
    end

    assign bus.in_ready = en[0];

    // Bitwise g/p for stage 0 and one prefix level per following stage.
    always_comb begin
        for (int k = 0; k <= LEVELS; k++) begin
            g_d[k]  = '0;
            gp_d[k] = '0;
            pb_d[k] = '0;
        end
        am_d = '0;
        bm_d = '0;

        g_d[0]  = {bus.A & ~bus.B, ~bus.Bin};
        gp_d[0] = {bus.A ^ ~bus.B, 1'b0};
        pb_d[0] = bus.A ^ ~bus.B;
        am_d[0] = bus.A[WIDTH-1];
        bm_d[0] = bus.B[WIDTH-1];

        for (int k = 1; k <= LEVELS; k++) begin
            for (int i = 0; i < EW; i++) begin
                if (i >= (1 << (k - 1))) begin
                    g_d[k][i]  = g_q[k-1][i] |
                                 (gp_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
                    gp_d[k][i] = gp_q[k-1][i] & gp_q[k-1][i - (1 << (k - 1))];
                end else begin
                    g_d[k][i]  = g_q[k-1][i];
                    gp_d[k][i] = gp_q[k-1][i];
                end
            end
            pb_d[k] = pb_q[k-1];
            am_d[k] = am_q[k-1];
            bm_d[k] = bm_q[k-1];
        end
    end

    // Final stage: sum bits, borrow-out and signed overflow.
    always_comb begin
        diff_d = pb_q[LEVELS] ^ g_q[LEVELS][WIDTH-1:0];
        cout   = g_q[LEVELS][WIDTH] | (gp_q[LEVELS][WIDTH] & g_q[LEVELS][0]);
        bout_d = ~cout;
        ovf_d  = (am_q[LEVELS] != bm_q[LEVELS]) && (diff_d[WIDTH-1] != am_q[LEVELS]);
    end

    // Stage-valid bits; reset drops every in-flight bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Prefix-stage data moves only when its stage captures a bundle.
    always_ff @(posedge clk) begin
        for (int k = 0; k <= LEVELS; k++) begin
            if (ld[k]) begin
                g_q[k]  <= g_d[k];
                gp_q[k] <= gp_d[k];
                pb_q[k] <= pb_d[k];
                am_q[k] <= am_d[k];
                bm_q[k] <= bm_d[k];
            end
        end
    end

    // Output register: cleared on reset, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (ld[NSTG-1]) begin
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.out_valid = vld_q[NSTG-1];
    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.Ovf       = ovf_q;
endmodule
